// File: rtl/filt_pkg.sv
// Shared definitions for the IIR filter datapath and its decimating averager.
// sfix16_En11 sample format, accumulator sizing and the output-register state type.
package filt_pkg;

  // sfix16_En11: 16-bit two's complement, 11 fractional bits.
  localparam int FILT_DATA_W = 16;
  localparam int FILT_FRAC_W = 11;

  typedef logic signed [FILT_DATA_W-1:0] filt_sample_t;

  // Output holding register: either empty or holding one unconsumed result.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // A block of up to 2^log2_max full-scale samples needs log2_max guard bits.
  function automatic int acc_width(input int log2_max);
    return FILT_DATA_W + log2_max;
  endfunction

  // Sample counter width; at least one bit even when decimation is disabled.
  function automatic int cnt_width(input int log2_max);
    return (log2_max > 0) ? log2_max : 1;
  endfunction

endpackage

// File: rtl/filt_decim_if.sv
// Sample-side and result-side signals of the decimating averager.
// Optional FILT_DECIM_OVR_CNT_EN adds the saturating dropped-result counter.
interface filt_decim_if;
  import filt_pkg::*;

  // Upstream: filter output and its sample strobe, plus block-length control.
  logic               sample_en;
  filt_sample_t       din;
  logic [2:0]         decim_log2;

  // Downstream: valid/ready result stream and overrun reporting.
  filt_sample_t       dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               overrun;
  logic               overrun_clr;

`ifdef FILT_DECIM_OVR_CNT_EN
  logic [15:0]        ovr_cnt;

  // Driver side: feeds samples, consumes results.
  modport master (
    output sample_en, din, decim_log2, dout_ready, overrun_clr,
    input  dout, dout_valid, overrun, ovr_cnt
  );

  // Averager side.
  modport slave (
    input  sample_en, din, decim_log2, dout_ready, overrun_clr,
    output dout, dout_valid, overrun, ovr_cnt
  );
`else
  // Driver side: feeds samples, consumes results.
  modport master (
    output sample_en, din, decim_log2, dout_ready, overrun_clr,
    input  dout, dout_valid, overrun
  );

  // Averager side.
  modport slave (
    input  sample_en, din, decim_log2, dout_ready, overrun_clr,
    output dout, dout_valid, overrun
  );
`endif

endinterface

// File: rtl/filt_round_shr.sv
// Round-half-up arithmetic right shift of a block sum by a runtime amount.
// A shift of zero passes the low sample bits straight through (single-sample block).
module filt_round_shr
  import filt_pkg::*;
#(
  parameter int ACC_W   = 22,
  parameter int SHIFT_W = 3
) (
  input  logic signed [ACC_W-1:0]   sum,
  input  logic        [SHIFT_W-1:0] shift,
  output filt_sample_t              result
);

  // One extra bit so adding the rounding half can never wrap.
  logic signed [ACC_W:0] sum_ext;
  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  // Add half an LSB of the output, then floor-shift: rounds .5 toward +inf.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum_ext = (ACC_W+1)'(sum);
    half    = '0;
    if (shift != '0) begin
      half = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
    end
    rounded = sum_ext + half;
    shifted = rounded >>> shift;
    // The average of 16-bit samples always fits back into 16 bits.
    result  = (shift == '0) ? sum[FILT_DATA_W-1:0] : shifted[FILT_DATA_W-1:0];
  end

endmodule

// File: rtl/filt_decim.sv
// Decimating averager behind the IIR section: averages blocks of 2^k strobed
// samples, rounds to sfix16_En11 and offers each result on a valid/ready port.
// Results arriving while the previous one is still unconsumed are dropped and
// flagged on the sticky overrun output.
// Build option: FILT_DECIM_OVR_CNT_EN adds a saturating count of dropped results.
module filt_decim
  import filt_pkg::*;
#(
  // Largest block exponent; decim_log2 is 3 bits, so at most 7.
  parameter int DECIM_LOG2_MAX = 6
) (
  input  logic       clk,
  input  logic       reset,
  filt_decim_if.slave bus
);

  localparam int         ACC_W = acc_width(DECIM_LOG2_MAX);
  localparam int         CNT_W = cnt_width(DECIM_LOG2_MAX);
  localparam logic [2:0] K_MAX = 3'(DECIM_LOG2_MAX);

  logic [2:0]              k_act;
  logic [2:0]              k_req;
  logic [2:0]              k_cur;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        last_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  filt_sample_t            result;
  logic                    block_done;
  logic                    handshake;
  logic                    drop;
  out_state_e              out_state;
  filt_sample_t            dout_q;
  logic                    overrun_q;

  // Block bookkeeping: the first sample of a block uses the live (clamped)
  // request, later samples use the exponent latched with that first sample.
  always_comb begin
    k_req      = (bus.decim_log2 > K_MAX) ? K_MAX : bus.decim_log2;
    k_cur      = (cnt == '0) ? k_req : k_act;
    last_cnt   = ~({CNT_W{1'b1}} << k_cur);
    sum        = acc + ACC_W'(bus.din);
    block_done = bus.sample_en && (cnt == last_cnt);
    handshake  = (out_state == OUT_FULL) && bus.dout_ready;
    drop       = block_done && (out_state == OUT_FULL) && !bus.dout_ready;
  end

  filt_round_shr #(
    .ACC_W   (ACC_W),
    .SHIFT_W (3)
  ) u_round (
    .sum    (sum),
    .shift  (k_cur),
    .result (result)
  );

  // Accumulate strobed samples; clear on block completion.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      k_act <= '0;
    end else if (bus.sample_en) begin
      if (cnt == '0) begin
        k_act <= k_req;
      end
      if (block_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output holding register with drop-on-stall and sticky overrun (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= OUT_EMPTY;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (out_state)
        OUT_EMPTY: begin
          if (block_done) begin
            dout_q    <= result;
            out_state <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (block_done && handshake) begin
            dout_q <= result;
          end else if (handshake) begin
            out_state <= OUT_EMPTY;
          end
        end
        default: out_state <= OUT_EMPTY;
      endcase

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (out_state == OUT_FULL);
  assign bus.overrun    = overrun_q;

`ifdef FILT_DECIM_OVR_CNT_EN
  logic [15:0] ovr_cnt_q;

  // Saturating count of dropped results; a drop outranks a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else if (drop) begin
      if (ovr_cnt_q != 16'hFFFF) begin
        ovr_cnt_q <= ovr_cnt_q + 16'd1;
      end
    end else if (bus.overrun_clr) begin
      ovr_cnt_q <= '0;
    end
  end

  assign bus.ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_filt_decim.sv
// Bench for filt_decim: a directed vector table, hand-written reset and
// k-change sequences, and randomized traffic against a block-average model.
module tb_filt_decim;
  import filt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  filt_decim_if ifc ();

  filt_decim #(.DECIM_LOG2_MAX(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (block-level arithmetic) ----------------
  int   blk[$];
  int   blk_k;
  logic m_valid;
  int   m_dout;
  logic m_ovr;
  int   m_cnt;

  function automatic int clamp_k(input int k);
    return (k > 6) ? 6 : k;
  endfunction

  // Mean of the block, rounded half up, using floor division.
  function automatic int block_avg();
    longint s = 0;
    longint n = longint'(1) << blk_k;
    longint num, q;
    foreach (blk[i]) s += blk[i];
    num = s + n / 2;
    q   = num / n;
    if ((num % n != 0) && (num < 0)) q = q - 1;
    return int'(q);
  endfunction

  task automatic drive(input logic se, input int d, input int k, input logic rdy, input logic clr);
    ifc.sample_en   = se;
    ifc.din         = 16'(d);
    ifc.decim_log2  = 3'(k);
    ifc.dout_ready  = rdy;
    ifc.overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // One cycle: advance the model, clock the DUT, compare.
  task automatic step(input logic se, input int d, input int k, input logic rdy, input logic clr);
    logic res_now = 1'b0;
    int   res = 0;
    logic hs, dropped;
    if (se) begin
      if (blk.size() == 0) blk_k = clamp_k(k);
      blk.push_back(d);
      if (blk.size() == (1 << blk_k)) begin
        res = block_avg();
        blk.delete();
        res_now = 1'b1;
      end
    end
    hs      = m_valid && rdy;
    dropped = m_valid && !rdy && res_now;
    if (res_now && (!m_valid || hs)) begin
      m_dout  = res;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (dropped) begin
      m_ovr = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end else if (clr) begin
      m_ovr = 1'b0;
      m_cnt = 0;
    end
    drive(se, d, k, rdy, clr);
    check("model_valid", int'(ifc.dout_valid), int'(m_valid));
    check("model_dout", int'(ifc.dout), m_dout);
    check("model_overrun", int'(ifc.overrun), int'(m_ovr));
`ifdef FILT_DECIM_OVR_CNT_EN
    check("model_ovr_cnt", int'(ifc.ovr_cnt), m_cnt);
`endif
  endtask

  task automatic do_reset();
    ifc.sample_en   = 1'b0;
    ifc.din         = '0;
    ifc.dout_ready  = 1'b0;
    ifc.overrun_clr = 1'b0;
    #2;
    reset = 1'b1;
    blk.delete();
    m_valid = 1'b0;
    m_dout  = 0;
    m_ovr   = 1'b0;
    m_cnt   = 0;
    #1;
    check("reset_valid", int'(ifc.dout_valid), 0);
    check("reset_dout", int'(ifc.dout), 0);
    check("reset_overrun", int'(ifc.overrun), 0);
`ifdef FILT_DECIM_OVR_CNT_EN
    check("reset_ovr_cnt", int'(ifc.ovr_cnt), 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic se; int din; int k; logic rdy; logic clr;
    logic exp_valid; int exp_dout; logic exp_ovr; int exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic se, input int din, input int k, input logic rdy,
                              input logic clr, input logic v, input int dout, input logic ovr,
                              input int cnt);
    vec_t t;
    t.se = se; t.din = din; t.k = k; t.rdy = rdy; t.clr = clr;
    t.exp_valid = v; t.exp_dout = dout; t.exp_ovr = ovr; t.exp_cnt = cnt;
    vecs.push_back(t);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    ifc.decim_log2 = 3'd0;

    // k=2: 100..103 averages to 101.5, rounds to 102, valid for one cycle.
    add(1, 100, 2, 1, 0, 0,   0, 0, 0);
    add(1, 101, 2, 1, 0, 0,   0, 0, 0);
    add(1, 102, 2, 1, 0, 0,   0, 0, 0);
    add(1, 103, 2, 1, 0, 1, 102, 0, 0);
    add(0,   0, 2, 1, 0, 0, 102, 0, 0);
    // k=3 full-scale extremes.
    for (int i = 0; i < 7; i++) add(1, -32768, 3, 1, 0, 0, 102, 0, 0);
    add(1, -32768, 3, 1, 0, 1, -32768, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 32767, 3, 1, 0, 0, -32768, 0, 0);
    add(1, 32767, 3, 1, 0, 1, 32767, 0, 0);
    add(0, 0, 3, 1, 0, 0, 32767, 0, 0);
    // k=0 pass-through, back-to-back strobes reload while consumed.
    add(1,  5, 0, 1, 0, 1,  5, 0, 0);
    add(1, -7, 0, 1, 0, 1, -7, 0, 0);
    add(0,  0, 0, 1, 0, 0, -7, 0, 0);
    // k=1, -2.5 rounds up to -2.
    add(1, -3, 1, 1, 0, 0, -7, 0, 0);
    add(1, -2, 1, 1, 0, 1, -2, 0, 0);
    add(0,  0, 1, 1, 0, 0, -2, 0, 0);
    // k=1 stalled consumer: second result dropped, overrun sticky, then cleared.
    add(1, 10, 1, 0, 0, 0, -2, 0, 0);
    add(1, 10, 1, 0, 0, 1, 10, 0, 0);
    add(1, 10, 1, 0, 0, 1, 10, 0, 0);
    add(1, 10, 1, 0, 0, 1, 10, 1, 1);
    add(0,  0, 1, 0, 1, 1, 10, 0, 0);
    add(0,  0, 1, 1, 0, 0, 10, 0, 0);
    // k=1 result coincides with handshake: reload, no overrun.
    add(1,  4, 1, 0, 0, 0, 10, 0, 0);
    add(1,  6, 1, 0, 0, 1,  5, 0, 0);
    add(1,  8, 1, 0, 0, 1,  5, 0, 0);
    add(1, 12, 1, 1, 0, 1, 10, 0, 0);
    add(0,  0, 1, 1, 0, 0, 10, 0, 0);
    // k=0 drop and clear in the same cycle: set wins.
    add(1, 1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 2, 0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].se, vecs[i].din, vecs[i].k, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), int'(ifc.dout_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_dout", i), int'(ifc.dout), vecs[i].exp_dout);
      check($sformatf("vec%0d_overrun", i), int'(ifc.overrun), int'(vecs[i].exp_ovr));
`ifdef FILT_DECIM_OVR_CNT_EN
      check($sformatf("vec%0d_ovr_cnt", i), int'(ifc.ovr_cnt), vecs[i].exp_cnt);
`endif
    end

    // Reset mid-block discards the partial sum; next block uses the new k.
    do_reset();
    step(1, 50, 2, 1, 0);
    step(1, 60, 2, 1, 0);
    do_reset();
    step(1, 20, 1, 1, 0);
    step(1, 30, 1, 1, 0);
    check("rst_newk_valid", int'(ifc.dout_valid), 1);
    check("rst_newk_dout", int'(ifc.dout), 25);

    // k change mid-block without reset: the 4-sample block completes first.
    step(1, 1, 2, 1, 0);
    step(1, 2, 2, 1, 0);
    step(1, 3, 1, 1, 0);
    step(1, 4, 1, 1, 0);
    check("kchg_blk4_dout", int'(ifc.dout), 3);
    check("kchg_blk4_valid", int'(ifc.dout_valid), 1);
    step(1, 7, 1, 1, 0);
    step(1, 8, 1, 1, 0);
    check("kchg_blk2_dout", int'(ifc.dout), 8);

    // Requested k=7 clamps to 64-sample blocks.
    for (int i = 0; i < 63; i++) step(1, 1000 + (i % 2), 7, 1, 0);
    check("clamp_not_yet", int'(ifc.dout_valid), 0);
    step(1, 1001, 7, 1, 0);
    check("clamp_dout", int'(ifc.dout), 1001);

    // Randomized traffic against the model.
    do_reset();
    begin
      int k = 2;
      for (int c = 0; c < 3000; c++) begin
        int   d;
        logic se, rdy, clr;
        if ($urandom_range(0, 39) == 0) k = $urandom_range(0, 7);
        case ($urandom_range(0, 7))
          0:       d = -32768;
          1:       d = 32767;
          default: d = int'($signed(16'($urandom)));
        endcase
        se  = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        clr = ($urandom_range(0, 15) == 0);
        step(se, d, k, rdy, clr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
